des_key_schedule: RTL
=====================

# des_key_schedule

Sequential DES round-key generator: takes the 64-bit key, applies PC-1, and delivers the 16 48-bit round subkeys (PC-2 of the rotated C/D halves) one per handshake. It supports encrypt order (K1..K16, left rotations) and decrypt order (K16..K1, right rotations). It sits between the key input and the round datapath, which consumes one subkey per round through a valid/ready handshake.

## Interface
- No parameters.
- Bit numbering: FIPS 46-3 bit n is index n-1 on every bus.
  - key[0] is key bit 1; C bit 1 is c[0]; subkey[0] is subkey bit 1.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a schedule; sampled only in IDLE.
- decrypt  input  1  sampled with start: 0 = K1..K16, 1 = K16..K1.
- key  input  64  DES key; parity bits (indices 7,15,…,63) ignored; sampled with start.
- subkey_ready  input  1  consumer accepts the current subkey.
- subkey_valid  output  1  subkey is valid.
- subkey  output  48  PC-2(C,D) of the current round.
- round  output  4  index of the subkey being presented.
  - Counts 0..15 in issue order, regardless of direction.
- busy  output  1  high in ACTIVE.
- done  output  1  one-cycle pulse after the final handshake.

## Operation
- FSM states:
  - IDLE: busy=0, subkey_valid=0.
  - ACTIVE: busy=1, subkey_valid=1.
- IDLE with start=1:
  - CD ← rot(PC1(key), s[0]); direction latched; round ← 0; go to ACTIVE.
- ACTIVE, handshake (subkey_valid & subkey_ready):
  - round < 15: CD ← rot(CD, s[round+1]); round ← round+1.
  - round = 15: go to IDLE; done=1 on the next cycle.
- ACTIVE without ready: CD, round and subkey hold stable.
- Rotation is applied to C and D independently, 28 bits each.
  - Left by k: x_next[i] = x[(i+k) mod 28].
  - Right by k: x_next[i] = x[(i−k) mod 28].
- Shift schedule s[r], r = 0..15:
  - Encrypt, left rotate: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Decrypt, right rotate: 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Decrypt r=0 presents K16, since the 28 total encrypt shifts restore C0D0.
- PC-1 and PC-2 are exact FIPS 46-3 tables under the numbering above.
  - C[j] = key[PC1[j]−1], j = 0..27; D[j] = key[PC1[28+j]−1].
- start during ACTIVE is ignored; decrypt and key are not resampled.
- Reset values:
  - State IDLE; subkey_valid=0, busy=0, done=0, round=0, CD=0.
  - subkey = PC2(0) = 0.
- Reset mid-schedule abandons the run. subkey_valid drops on the cycle after rst is sampled, and no done is issued.

## Timing
- start sampled at edge t → subkey_valid=1 with K1 (or K16) from t+1.
- With subkey_ready held high, 16 subkeys are delivered on 16 consecutive cycles.
  - done pulses on the cycle after the 16th handshake.
  - A new start is accepted in that same done cycle.
- subkey is a registered-CD function: PC-2 is pure wiring, so output depth is 0 gates after the CD flops.
- Throughput: 1 subkey/cycle. Latency start→first valid: 1 cycle.

## Structure
- Package des_pkg:
  - PC1 and PC2 index tables and SHIFT_ENC/SHIFT_DEC 16-entry arrays.
  - Typedef for the 28-bit half-key and the 48-bit subkey.
- Sub-module des_pc2: combinational 56→48 permutation, instantiated once on the CD register.
- PC-1 is inlined at load.
- Rotation is a 2-bit-amount mux function in the package.

## Test plan
- Encrypt, FIPS vector: key hex 133457799BBCDFF1 applied with key[i] = hex bit (63−i), start, ready=1.
  - 16 consecutive valids; round 0 subkey = bit-reverse of 1B02EFFC7072.
  - round 15 = bit-reverse of CB3D8B0E17F5; done pulse 1 cycle after.
- Decrypt, same key: first subkey equals the encrypt K16 and the last equals K1.
  - Full sequence is the exact reverse of the encrypt run.
- Backpressure: ready toggles randomly with 0–3-cycle stalls.
  - subkey and round hold while valid & !ready; sequence is identical to the stall-free run.
- Parity independence: flip all eight parity bits of the key.
  - All 16 subkeys are unchanged.
- start while busy is ignored. rst asserted at round 7 → next cycle valid=0, busy=0, round=0, no done.
  - A fresh start then produces a correct K1.
- Back-to-back: start asserted in the done cycle → new K1 is valid on the next cycle.

Source files
------------

// File: rtl/des_pkg.sv
// DES key-schedule constants and helpers.
// - PC1 / PC2: FIPS 46-3 permutation tables, 1-based bit numbers.
// - SHIFT_ENC / SHIFT_DEC: per-round rotation amounts.
// - half_t (28-bit C or D half) and subkey_t (48-bit round key).
// - rot(): rotates one 28-bit half left or right by 0..2.
// Bus index 0 is FIPS bit 1.
package des_pkg;

    typedef logic [27:0] half_t;
    typedef logic [47:0] subkey_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam logic [1:0] SHIFT_ENC [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Decrypt starts with 0: the full encrypt rotation total of 28 brings
    // C/D back to C0/D0, which is exactly what K16 needs.
    localparam logic [1:0] SHIFT_DEC [16] = '{
        2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Because index 0 is bit 1, a FIPS "left" rotation moves data toward
    // lower indices (x_next[i] = x[i+k]).
    function automatic half_t rot(input half_t x, input logic [1:0] amt,
                                  input logic right);
        half_t r;
        r = x;
        case (amt)
            2'd1:    r = right ? {x[26:0], x[27]}    : {x[0],    x[27:1]};
            2'd2:    r = right ? {x[25:0], x[27:26]} : {x[1:0],  x[27:2]};
            default: r = x;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/des_pc2.sv
// PC-2 compression permutation: 56-bit C/D to 48-bit subkey.
// - cd: {D, C}, so cd[0] is C bit 1 and cd[28] is D bit 1.
// - subkey: subkey[0] is subkey bit 1.
// This block is wiring only, with no gates.
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] cd,
    output subkey_t     subkey
);

    generate
        for (genvar gi = 0; gi < 48; gi++) begin : g_pc2
            assign subkey[gi] = cd[PC2[gi] - 1];
        end
    endgenerate

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES round-key generator.
// - start (sampled in IDLE) loads PC-1(key) into C/D and latches decrypt.
// - One subkey is presented per valid/ready handshake.
//   - Encrypt order: K1..K16 with left rotations.
//   - Decrypt order: K16..K1 with right rotations.
// - round counts 0..15 in issue order.
// - busy is high while presenting.
// - done pulses for one cycle after the 16th handshake.
// - subkey is PC-2 of the C/D registers.
module des_key_schedule
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key,
    input  logic        subkey_ready,
    output logic        subkey_valid,
    output logic [47:0] subkey,
    output logic [3:0]  round,
    output logic        busy,
    output logic        done
);

    state_t      state_reg, state_next;
    half_t       c_reg, c_next, d_reg, d_next;
    logic [3:0]  round_reg, round_next;
    logic        dir_reg, dir_next;
    logic        done_reg, done_next;

    half_t       pc1_c, pc1_d;
    logic [3:0]  round_inc;
    logic [1:0]  amt_adv;
    logic [1:0]  amt_load;

    // PC-1 at load. Parity bits are simply never selected.
    generate
        for (genvar gi = 0; gi < 28; gi++) begin : g_pc1
            assign pc1_c[gi] = key[PC1[gi] - 1];
            assign pc1_d[gi] = key[PC1[28 + gi] - 1];
        end
    endgenerate

    assign round_inc = round_reg + 4'd1;
    assign amt_adv   = dir_reg ? SHIFT_DEC[round_inc] : SHIFT_ENC[round_inc];
    assign amt_load  = decrypt ? SHIFT_DEC[0] : SHIFT_ENC[0];

    always_comb begin
        state_next = state_reg;
        c_next     = c_reg;
        d_next     = d_reg;
        round_next = round_reg;
        dir_next   = dir_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    c_next     = rot(pc1_c, amt_load, decrypt);
                    d_next     = rot(pc1_d, amt_load, decrypt);
                    dir_next   = decrypt;
                    round_next = 4'd0;
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (subkey_ready) begin
                    if (round_reg == 4'd15) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                        round_next = 4'd0;
                    end else begin
                        c_next     = rot(c_reg, amt_adv, dir_reg);
                        d_next     = rot(d_reg, amt_adv, dir_reg);
                        round_next = round_inc;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            c_reg     <= '0;
            d_reg     <= '0;
            round_reg <= 4'd0;
            dir_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            c_reg     <= c_next;
            d_reg     <= d_next;
            round_reg <= round_next;
            dir_reg   <= dir_next;
            done_reg  <= done_next;
        end
    end

    des_pc2 u_pc2 (
        .cd     ({d_reg, c_reg}),
        .subkey (subkey)
    );

    assign subkey_valid = (state_reg == ACTIVE);
    assign busy         = (state_reg == ACTIVE);
    assign round        = round_reg;
    assign done         = done_reg;

endmodule
